// File: rtl/uart_rx.sv
// uart_rx: 8N1 byte receiver. It samples a 2-flop-synchronized serial line at
// mid-bit, holds the last accepted byte in rx_data, and reports busy,
// data_ready, overrun and framing_error in status_register.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    input  logic [7:0] control_register,
    input  logic       read_rx_data,
    output logic [7:0] rx_data,
    output logic [7:0] status_register
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_next;
    logic [7:0]    shift_reg;
    logic          data_ready;
    logic          overrun;
    logic          framing_error;
    logic          enable;
    logic          sample_data;
    logic          complete;
    logic          busy;
    logic          unused_ctrl;

    assign enable      = control_register[0];
    assign unused_ctrl = ^control_register[7:1];
    assign busy        = (state != IDLE);

    assign status_register = {4'b0000, framing_error, overrun, data_ready, busy};

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register together with the bit and clock counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Next-state logic; disabling the receiver aborts any frame back to IDLE.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_cnt_next = bit_cnt;
        sample_data  = 1'b0;
        complete     = 1'b0;
        if (!enable) begin
            state_next   = IDLE;
            clk_cnt_next = '0;
            bit_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    if (!rxs) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt_next = '0;
                        state_next   = rxs ? IDLE : DATA;
                    end else begin
                        clk_cnt_next = clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt_next = '0;
                        sample_data  = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_next = '0;
                            state_next   = STOP;
                        end else begin
                            bit_cnt_next = bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt_next = clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt_next = '0;
                        complete     = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        clk_cnt_next = clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state_next   = IDLE;
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                end
            endcase
        end
    end

    // Data path: shift in data bits, then deliver the byte and update flags.
    // A completion landing on a read cycle still loads the byte and keeps
    // data_ready, while the read clears the older overrun/framing state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg     <= 8'h00;
            rx_data       <= 8'h00;
            data_ready    <= 1'b0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (sample_data) begin
                shift_reg[bit_cnt] <= rxs;
            end
            if (complete) begin
                if (!data_ready || read_rx_data) begin
                    rx_data    <= shift_reg;
                    data_ready <= 1'b1;
                    overrun    <= read_rx_data ? 1'b0 : overrun;
                end else begin
                    overrun <= 1'b1;
                end
                if (!rxs) begin
                    framing_error <= 1'b1;
                end else if (read_rx_data) begin
                    framing_error <= 1'b0;
                end
            end else if (read_rx_data) begin
                data_ready    <= 1'b0;
                overrun       <= 1'b0;
                framing_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives bit-accurate 8N1 frames into uart_rx and compares
// rx_data/status_register against a byte-level model of the receiver rules.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] control_register;
    logic       read_rx_data;
    logic [7:0] rx_data;
    logic [7:0] status_register;

    int checks = 0;
    int passed = 0;

    logic [7:0] mData;
    bit         mReady;
    bit         mOvr;
    bit         mFerr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .rx               (rx),
        .control_register (control_register),
        .read_rx_data     (read_rx_data),
        .rx_data          (rx_data),
        .status_register  (status_register)
    );

    // 20 ns system clock
    always #10 clock = ~clock;

    function automatic logic [7:0] mStatus(input bit busy);
        return {4'b0000, mFerr, mOvr, mReady, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    endtask

    task automatic modelReset();
        mData  = 8'h00;
        mReady = 0;
        mOvr   = 0;
        mFerr  = 0;
    endtask

    task automatic modelRead();
        mReady = 0;
        mOvr   = 0;
        mFerr  = 0;
    endtask

    task automatic modelComplete(input logic [7:0] b, input bit stopBit, input bit rd);
        bit wasReady;
        wasReady = mReady;
        if (rd) begin
            mOvr  = 0;
            mFerr = 0;
        end
        if (!wasReady || rd) begin
            mData  = b;
            mReady = 1;
        end else begin
            mOvr = 1;
        end
        if (!stopBit) mFerr = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic readPulse();
        @(posedge clock);
        #1 read_rx_data = 1'b1;
        @(posedge clock);
        #1 read_rx_data = 1'b0;
        modelRead();
        checkOutput("readClear", status_register, mStatus(0));
    endtask

    // One frame, k counts clocks from the edge before the start bit.
    // mode 0: no read, 1: read on the completion cycle, 2: read just after.
    // cutAt >= 0 aborts the frame at that clock via disable or reset.
    task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input int mode,
                                 input int cutAt, input bit cutReset);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            @(posedge clock);
            #1;
            rx = frame[k / CPB];
            read_rx_data = (mode == 1 && k == 154) || (mode == 2 && k == 156);
            if (k == cutAt) begin
                if (cutReset) begin
                    reset_n = 1'b0;
                    #1;
                    modelReset();
                    checkOutput("resetData", rx_data, 8'h00);
                    checkOutput("resetStatus", status_register, 8'h00);
                    rx = 1'b1;
                    repeat (3) @(posedge clock);
                    #3 reset_n = 1'b1;
                end else begin
                    control_register[0] = 1'b0;
                    @(posedge clock);
                    #1;
                    checkOutput("disableStatus", status_register, mStatus(0));
                    checkOutput("disableData", rx_data, mData);
                    rx = 1'b1;
                    repeat (3) @(posedge clock);
                    #1 control_register[0] = 1'b1;
                end
                break;
            end
            if (k == 2) checkOutput("idleBeforeStart", status_register, mStatus(0));
            if (k == 3) checkOutput("busyInStart", status_register, mStatus(1));
            if (k == 154) begin
                checkOutput("preStopStatus", status_register, mStatus(1));
                checkOutput("preStopData", rx_data, mData);
            end
            if (k == 155) begin
                modelComplete(b, stopBit, mode == 1);
                checkOutput("doneData", rx_data, mData);
                checkOutput("doneStatus", status_register, mStatus(0));
            end
            if (mode == 2 && k == 157) begin
                modelRead();
                checkOutput("readAfterStatus", status_register, mStatus(0));
            end
        end
        read_rx_data = 1'b0;
        rx = 1'b1;
    endtask

    // Short low pulse on rx that must be rejected at the start-bit sample.
    task automatic glitch();
        @(posedge clock);
        #1 rx = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(posedge clock);
            #1;
            if (k == 4) rx = 1'b1;
            if (k == 5) checkOutput("glitchBusy", status_register, mStatus(1));
            if (k == 12) checkOutput("glitchIdle", status_register, mStatus(0));
        end
    endtask

    initial begin
        logic [7:0] msg [7];
        logic [7:0] b;
        bit         stopBit;
        int         mode;

        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h20};
        reset_n          = 1'b0;
        rx               = 1'b1;
        read_rx_data     = 1'b0;
        control_register = 8'h00;
        modelReset();
        #5;
        checkOutput("resetStateData", rx_data, 8'h00);
        checkOutput("resetStateStatus", status_register, 8'h00);
        #30 reset_n = 1'b1;
        control_register = 8'h01;
        idle(5);

        $display("[TB] single byte");
        applyStimulus(8'h48, 1'b1, 0, -1, 1'b0);
        readPulse();

        $display("[TB] string");
        foreach (msg[i]) applyStimulus(msg[i], 1'b1, 2, -1, 1'b0);

        $display("[TB] overrun");
        applyStimulus(8'h55, 1'b1, 0, -1, 1'b0);
        applyStimulus(8'hAA, 1'b1, 0, -1, 1'b0);
        readPulse();

        $display("[TB] framing error");
        applyStimulus(8'h3C, 1'b0, 0, -1, 1'b0);
        idle(40);
        readPulse();

        $display("[TB] false start and simultaneous read");
        glitch();
        applyStimulus(8'h5A, 1'b1, 0, -1, 1'b0);
        applyStimulus(8'hC3, 1'b1, 1, -1, 1'b0);

        $display("[TB] disable and reset mid-frame");
        applyStimulus(8'h77, 1'b1, 0, 78, 1'b0);
        idle(20);
        applyStimulus(8'h99, 1'b1, 0, 90, 1'b1);
        idle(5);
        applyStimulus(8'h21, 1'b1, 0, -1, 1'b0);
        readPulse();

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            b       = 8'($urandom);
            stopBit = ($urandom_range(0, 7) != 0);
            mode    = $urandom_range(0, 2);
            if (!stopBit && mode == 2) mode = 0;
            control_register = {7'($urandom), 1'b1};
            applyStimulus(b, stopBit, mode, -1, 1'b0);
            if (!stopBit) idle(40);
            if ($urandom_range(0, 3) == 0) readPulse();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-level UART receiver: the stage that consumes the serial line driven by `uart` (transmitter). It samples an 8N1 frame (start bit, 8 data bits LSB first, 1 stop bit) at a fixed bit period and holds the received byte in a data register. Handshake flags sit in a status register, and enable control comes from a control register, with the same register style as the transmitter. In the loopback test system, `rx` is wired to the transmitter's `tx`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `clock`, input, 1: system clock; all logic on the rising edge.
- `reset_n`, input, 1: asynchronous active-low reset.
- `rx`, input, 1: serial line; idles high; asynchronous to `clock`.
- `control_register`, input, 8: bit0 = rx enable; bits 7:1 reserved and ignored.
- `read_rx_data`, input, 1: acknowledge, sampled each clock; a high cycle consumes the byte and clears the flags.
- `rx_data`, output, 8: last accepted byte.
- `status_register`, output, 8:
  - bit0 = busy (frame in progress)
  - bit1 = data_ready
  - bit2 = overrun
  - bit3 = framing_error
  - bits 7:4 = 0

## Operation
- `rx` passes through a 2-flop synchronizer with reset value 1. All logic uses the synchronized value `rxs`.
- State machine: IDLE, START, DATA, STOP.
- **IDLE.** Bit counter = 0, clock counter = 0. If enable = 1 and `rxs` = 0, go to START.
- **START.** Count `CLKS_PER_BIT/2` cycles (integer division), then sample `rxs`.
  - Sample = 0: go to DATA with the clock counter cleared.
  - Sample = 1 (glitch/false start): go to IDLE, no flags change.
- **DATA.** Every `CLKS_PER_BIT` cycles, sample `rxs` into shift register bit [bit counter], LSB first. After the 8th sample (bit counter = 7), go to STOP.
- **STOP.** After `CLKS_PER_BIT` cycles, sample the stop bit, complete the frame, and go to IDLE in the same cycle.
- **Frame completion**, on the stop-sample cycle:
  - If data_ready = 0, or `read_rx_data` = 1 in this same cycle: load `rx_data` with the shift register and set data_ready = 1.
  - Otherwise: set overrun = 1; `rx_data` is not overwritten and the new byte is discarded.
  - Stop sample = 0: set framing_error = 1. The byte is still delivered under the same rules as above.
- **Read.** `read_rx_data` = 1 clears data_ready, overrun and framing_error on the next edge. A completion in the same cycle takes priority for data_ready: it stays 1 and the new byte is loaded. The same-cycle completion's own framing_error is also retained. Read while data_ready = 0 has no effect.
- busy = 1 in START, DATA and STOP; 0 in IDLE.
- **Disable** (enable = 0) in any non-IDLE state aborts to IDLE on the next edge. A partial byte is dropped; `rx_data` and the flags are held.
- **Reset values:**
  - state IDLE, counters 0
  - `rx_data` = 8'h00
  - `status_register` = 8'h00
  - synchronizer flops = 1

## Timing
- Synchronizer latency: 2 clocks from an `rx` edge to `rxs`.
- Start detection is in the first clock `rxs` reads 0 while in IDLE.
- START-bit sample: `CLKS_PER_BIT/2` cycles after entering START.
- Data bit n (n = 0..7) sample: `(n+1)·CLKS_PER_BIT` cycles after the START-bit sample.
- Stop sample, at which the flags and `rx_data` update on the same edge: `9·CLKS_PER_BIT` cycles after the START-bit sample.
- Back-to-back frames: the next start bit may begin immediately after the nominal stop-bit end. The receiver is back in IDLE about half a bit early, so no frame is missed.
- `rx_data` is stable whenever data_ready = 1.
- Async reset takes effect immediately regardless of the clock, including mid-frame.

## Test plan
Bench uses `CLKS_PER_BIT` = 16 with a 20 ns clock, driving `rx` from a bit-accurate model or the `uart` transmitter in loopback.
- **Single byte.** Reset, enable, send 8'h48 → `rx_data` = 8'h48 and `status_register` = 8'h02 at the stop sample. busy is high during the frame. Pulse `read_rx_data` → status = 8'h00.
- **String.** Send "Hello! " back-to-back, reading each byte as data_ready rises → bytes 48,65,6C,6C,6F,21,20 received in order, with overrun and framing_error never set.
- **Overrun.** Send 8'h55, then 8'hAA without reading → `rx_data` stays 8'h55 and status = 8'h06. Read → 8'h00.
- **Framing error.** Send 8'h3C with stop bit = 0 → `rx_data` = 8'h3C, status = 8'h0A.
- **False start and simultaneous read.**
  - A 4-clock low glitch on `rx` → no busy after START, status = 8'h00.
  - Assert `read_rx_data` exactly on the completion cycle of a second byte → data_ready stays 1, new byte loaded, overrun = 0.
- **Disable and reset mid-frame.**
  - Drop enable after bit 3 → busy = 0 next cycle, `rx_data` unchanged, no flags set.
  - Assert `reset_n` = 0 mid-frame → `rx_data` = 8'h00 and status = 8'h00 immediately.
  - Release reset, send a full 8'h21 → received correctly.
